wb_mem_bist: RTL and testbench
==============================

Name: wb_mem_bist

Overview:
- Wishbone initiator (master) that tests a word-addressed Wishbone memory slave, such as the on-chip RAM.
- Write pass: fills N consecutive 32-bit words with an LFSR pattern.
- Read pass: regenerates the pattern from the same seed and compares each returned word.
- Reports pass/fail, the first failing address and data, and a fail cause.
- Sits on the system Wishbone bus beside the CPU; used for board bring-up and post-reset memory self-test.

Parameters:
- TO_CYCLES, 16, watchdog limit in clocks per bus transfer (used only with the optional feature).
- POLY, 32'h80200003, Galois LFSR feedback polynomial.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle start request; ignored while busy_o=1.
- base_adr_i  in  32  first byte address; bits[1:0] forced to 0.
- words_i  in  16  number of words to test; 0 is legal.
- seed_i  in  32  LFSR seed; 0 is replaced by 32'h1.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test end.
- pass_o  out  1  result of last test; held until next start.
- fail_code_o  out  2  0 none, 1 data mismatch, 2 bus error, 3 timeout.
- fail_adr_o  out  32  address of first failure.
- fail_dat_o  out  32  read data at failure (0 for error/timeout).
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle, 0 otherwise.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.

Behaviour:
- Clock and reset: one clock (wb_clk_i); reset wb_rst_ni is asynchronous and active-low.
- Reset values: all outputs 0. pass_o=0, fail_code_o=0, wbm_cyc_o=0, wbm_stb_o=0. FSM goes to IDLE. Reset mid-test drops cyc/stb immediately (asynchronous) and abandons the test.
- FSM states: IDLE, WR, WR_GAP, RD, RD_GAP, FIN.
- IDLE:
  - start_i loads adr=base_adr_i&~3, cnt=words_i, lfsr=seed (0 becomes 1).
  - Clears pass_o and fail_*.
  - Next state is WR, or FIN if words_i==0 (pass then reported).
- WR:
  - Drives cyc=stb=we=1, sel=F, adr, dat=lfsr, and holds them stable until ack or err.
  - On ack: lfsr advances, adr+=4 (mod 2^32 wrap), cnt-=1; next state WR_GAP.
  - On err: abort to FIN with code 2.
- WR_GAP:
  - cyc=stb=0 for exactly one clock; single transfers only, no pipelining.
  - If cnt==0: reload adr, cnt and lfsr from the values captured at start, then go to RD. Otherwise go to WR.
- RD:
  - Drives cyc=stb=1, we=0, sel=F, adr.
  - On ack: compare wbm_dat_i to lfsr.
    - Mismatch: capture adr/data, code 1, go to FIN (stop at first mismatch).
    - Match: advance and go to RD_GAP.
  - On err: code 2, go to FIN.
- RD_GAP: one idle clock; next state FIN if cnt==0, else RD.
- FIN: done_o=1 for one clock; pass_o=(code==0); next state IDLE. busy_o=1 in every state except IDLE.
- Simultaneous ack and err: err wins.
- start_i in the same cycle as FIN is ignored.
- LFSR step: next = (x>>1) ^ (x[0] ? POLY : 0). The first word uses the seed itself.
- Latency: with a 1-wait slave, 2 clocks of bus time plus 1 gap clock per word.

Optional Feature:
- Macro: WB_MEM_BIST_TIMEOUT_EN.
- With the macro:
  - A per-transfer counter is cleared on entry to WR/RD.
  - If it reaches TO_CYCLES without ack or err: drop cyc/stb, set code 3, fail_adr=adr, go to FIN.
- Without the macro: the master waits indefinitely; code 3 is never produced and no counter logic is synthesized.

Decomposition:
- Package wb_mem_bist_pkg holds:
  - FSM state encoding;
  - fail-code constants (FAIL_NONE, FAIL_MISMATCH, FAIL_BUSERR, FAIL_TIMEOUT);
  - default POLY.
- One sub-module, wb_mem_bist_lfsr: seed load, step enable, current value.

Test Plan:
- Seed 1, words 3, base 0x0, zero-wait-error-free RAM model -> writes 0x00000001, 0x80200003, 0xC0300002 to 0x0/0x4/0x8; reads match; done pulse; pass_o=1, code 0; every transfer is followed by one cyc=0 clock.
- words_i=0 -> no cyc asserted; done_o one clock after start; pass_o=1.
- Model corrupts the read at 0x104 (base 0x100, seed 1) -> code 1, fail_adr=0x104, fail_dat=the corrupted value, pass_o=0, no further transfers.
- err asserted on the second write (base 0x0) -> cyc drops, code 2, fail_adr=0x4, no read pass.
- With WB_MEM_BIST_TIMEOUT_EN and TO_CYCLES=16, slave never acks -> cyc drops after 16 clocks, code 3; without the macro, cyc stays high indefinitely.
- wb_rst_ni low during the read pass -> cyc/stb go 0 asynchronously; outputs at reset values; a new start runs cleanly; start_i pulsed while busy has no effect.

Source files
------------

// File: rtl/wb_mem_bist_pkg.sv
// rtl/wb_mem_bist_pkg.sv - shared types, fail codes and LFSR step for wb_mem_bist
package wb_mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD     = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_MISMATCH = 2'd1;
    localparam logic [1:0] FAIL_BUSERR   = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd3;

    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

    // Galois right-shift form: feedback applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] poly);
        return (x >> 1) ^ (x[0] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/wb_mem_bist_lfsr.sv
// rtl/wb_mem_bist_lfsr.sv - Galois LFSR pattern source with seed load and step enable
module wb_mem_bist_lfsr
    import wb_mem_bist_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] value_o
);

    logic [31:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = seed_i;
        end else if (step_i) begin
            value_d = lfsr_next(value_q, POLY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/wb_mem_bist.sv
// rtl/wb_mem_bist.sv - Wishbone master that fills memory with an LFSR pattern and reads it back
// Optional per-transfer watchdog (fail code 3) enabled by defining WB_MEM_BIST_TIMEOUT_EN.
module wb_mem_bist
    import wb_mem_bist_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 16,
    parameter logic [31:0] POLY      = DEFAULT_POLY
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic [31:0] base_adr_i,
    input  logic [15:0] words_i,
    input  logic [31:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [1:0]  fail_code_o,
    output logic [31:0] fail_adr_o,
    output logic [31:0] fail_dat_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] base_q, base_d;
    logic [31:0] seed_q, seed_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] words_q, words_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] fail_adr_q, fail_adr_d;
    logic [31:0] fail_dat_q, fail_dat_d;
    logic        pass_q, pass_d;

    logic        lfsr_load;
    logic        lfsr_step;
    logic [31:0] lfsr_seed;
    logic [31:0] lfsr_val;
    logic        in_xfer;
    logic        to_hit;

    wb_mem_bist_lfsr #(
        .POLY (POLY)
    ) u_lfsr (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .load_i  (lfsr_load),
        .seed_i  (lfsr_seed),
        .step_i  (lfsr_step),
        .value_o (lfsr_val)
    );

    assign in_xfer = (state_q == ST_WR) || (state_q == ST_RD);

`ifdef WB_MEM_BIST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Counts clocks spent waiting inside one transfer; gaps and FIN clear it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_cnt_q <= '0;
        end else if (in_xfer && !wbm_ack_i && !wbm_err_i) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign to_hit = (to_cnt_q == TO_W'(TO_CYCLES - 1));
`else
    localparam int unsigned unused_to_cycles = TO_CYCLES;

    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        base_d     = base_q;
        seed_d     = seed_q;
        cnt_d      = cnt_q;
        words_d    = words_q;
        code_d     = code_q;
        fail_adr_d = fail_adr_q;
        fail_dat_d = fail_dat_q;
        pass_d     = pass_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        lfsr_seed  = seed_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d     = base_adr_i & ~32'h3;
                    words_d    = words_i;
                    seed_d     = (seed_i == 32'h0) ? 32'h1 : seed_i;
                    adr_d      = base_d;
                    cnt_d      = words_i;
                    lfsr_load  = 1'b1;
                    lfsr_seed  = seed_d;
                    code_d     = FAIL_NONE;
                    fail_adr_d = '0;
                    fail_dat_d = '0;
                    pass_d     = 1'b0;
                    state_d    = (words_i == 16'h0) ? ST_FIN : ST_WR;
                end
            end

            ST_WR: begin
                if (wbm_err_i) begin
                    code_d     = FAIL_BUSERR;
                    fail_adr_d = adr_q;
                    fail_dat_d = '0;
                    state_d    = ST_FIN;
                end else if (wbm_ack_i) begin
                    lfsr_step = 1'b1;
                    adr_d     = adr_q + 32'd4;
                    cnt_d     = cnt_q - 16'd1;
                    state_d   = ST_WR_GAP;
                end else if (to_hit) begin
                    code_d     = FAIL_TIMEOUT;
                    fail_adr_d = adr_q;
                    fail_dat_d = '0;
                    state_d    = ST_FIN;
                end
            end

            ST_WR_GAP: begin
                if (cnt_q == 16'h0) begin
                    adr_d     = base_q;
                    cnt_d     = words_q;
                    lfsr_load = 1'b1;
                    lfsr_seed = seed_q;
                    state_d   = ST_RD;
                end else begin
                    state_d = ST_WR;
                end
            end

            ST_RD: begin
                if (wbm_err_i) begin
                    code_d     = FAIL_BUSERR;
                    fail_adr_d = adr_q;
                    fail_dat_d = '0;
                    state_d    = ST_FIN;
                end else if (wbm_ack_i) begin
                    if (wbm_dat_i != lfsr_val) begin
                        code_d     = FAIL_MISMATCH;
                        fail_adr_d = adr_q;
                        fail_dat_d = wbm_dat_i;
                        state_d    = ST_FIN;
                    end else begin
                        lfsr_step = 1'b1;
                        adr_d     = adr_q + 32'd4;
                        cnt_d     = cnt_q - 16'd1;
                        state_d   = ST_RD_GAP;
                    end
                end else if (to_hit) begin
                    code_d     = FAIL_TIMEOUT;
                    fail_adr_d = adr_q;
                    fail_dat_d = '0;
                    state_d    = ST_FIN;
                end
            end

            ST_RD_GAP: begin
                state_d = (cnt_q == 16'h0) ? ST_FIN : ST_RD;
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The verdict becomes visible in the same clock as the done pulse.
        if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
            pass_d = (code_d == FAIL_NONE);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            base_q     <= '0;
            seed_q     <= '0;
            cnt_q      <= '0;
            words_q    <= '0;
            code_q     <= FAIL_NONE;
            fail_adr_q <= '0;
            fail_dat_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            base_q     <= base_d;
            seed_q     <= seed_d;
            cnt_q      <= cnt_d;
            words_q    <= words_d;
            code_q     <= code_d;
            fail_adr_q <= fail_adr_d;
            fail_dat_q <= fail_dat_d;
            pass_q     <= pass_d;
        end
    end

    assign wbm_cyc_o   = in_xfer;
    assign wbm_stb_o   = in_xfer;
    assign wbm_we_o    = (state_q == ST_WR);
    assign wbm_sel_o   = in_xfer ? 4'hF : 4'h0;
    assign wbm_adr_o   = in_xfer ? adr_q : 32'h0;
    assign wbm_dat_o   = (state_q == ST_WR) ? lfsr_val : 32'h0;

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_FIN);
    assign pass_o      = pass_q;
    assign fail_code_o = code_q;
    assign fail_adr_o  = fail_adr_q;
    assign fail_dat_o  = fail_dat_q;

endmodule

// File: tb/tb_wb_mem_bist.sv
// tb/tb_wb_mem_bist.sv - self-checking bench for wb_mem_bist with RAM slave and transfer-level model
module tb_wb_mem_bist;

    localparam int          TO      = 16;
    localparam logic [31:0] CORRUPT = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = 32'h0;
    logic [15:0] words = 16'h0;
    logic [31:0] seed = 32'h0;
    logic        busy, done, pass;
    logic [1:0]  code;
    logic [31:0] fadr, fdat;
    logic [31:0] m_adr, m_dato;
    logic [31:0] m_dati = 32'h0;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    logic        m_ack = 1'b0;
    logic        m_err = 1'b0;

    int checks = 0;
    int errors = 0;

    int          err_idx = -1;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_adr = 32'h0;
    bit          no_ack = 1'b0;

    logic [31:0] mem [logic [31:0]];
    bit          running = 1'b0;
    bit          acked_last = 1'b0;
    int          offs = 0, xidx = 0, nx = 0, done_cnt = 0, cyc_len = 0, last_cyc_len = 0;
    logic [31:0] xadr [128];
    logic [31:0] xdat [128];
    bit          xwe  [128];
    logic [1:0]  e_code;
    logic [31:0] e_fadr, e_fdat;
    int          e_done_at;

    wb_mem_bist #(
        .TO_CYCLES (TO),
        .POLY      (32'h80200003)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .start_i     (start),
        .base_adr_i  (base),
        .words_i     (words),
        .seed_i      (seed),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .fail_code_o (code),
        .fail_adr_o  (fadr),
        .fail_dat_o  (fdat),
        .wbm_adr_o   (m_adr),
        .wbm_dat_o   (m_dato),
        .wbm_dat_i   (m_dati),
        .wbm_sel_o   (m_sel),
        .wbm_we_o    (m_we),
        .wbm_cyc_o   (m_cyc),
        .wbm_stb_o   (m_stb),
        .wbm_ack_i   (m_ack),
        .wbm_err_i   (m_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Expected transfer list and verdict for the test just accepted.
    task automatic build();
        logic [31:0] lf, a, x0;
        bit stop;
        stop   = 1'b0;
        x0     = (seed == 32'h0) ? 32'h1 : seed;
        nx     = 0;
        e_code = 2'd0;
        e_fadr = 32'h0;
        e_fdat = 32'h0;
        for (int p = 0; p < 2 && !stop; p++) begin
            lf = x0;
            a  = base & ~32'h3;
            for (int i = 0; i < int'(words) && !stop && nx < 128; i++) begin
                xwe[nx]  = (p == 0);
                xadr[nx] = a;
                xdat[nx] = lf;
                if (no_ack) begin
                    e_code = 2'd3; e_fadr = a; stop = 1'b1;
                end else if (nx == err_idx) begin
                    e_code = 2'd2; e_fadr = a; stop = 1'b1;
                end else if (p == 1 && corrupt_en && a == corrupt_adr) begin
                    e_code = 2'd1; e_fadr = a; e_fdat = CORRUPT; stop = 1'b1;
                end
                nx++;
                lf = model_next(lf);
                a  = a + 32'd4;
            end
        end
        e_done_at = stop ? (no_ack ? TO + 1 : 2 * nx) : 4 * int'(words) + 1;
    endtask

    // Slave responses plus per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            running    = 1'b0;
            acked_last = 1'b0;
            m_ack      = 1'b0;
            m_err      = 1'b0;
            cyc_len    = 0;
            chk("rst_cyc", {31'h0, m_cyc}, 32'h0);
        end else begin
            chk("busy", {31'h0, busy}, {31'h0, running});
            if (acked_last) chk("gap_cyc", {31'h0, m_cyc}, 32'h0);
            acked_last = 1'b0;
            m_ack      = 1'b0;
            m_err      = 1'b0;
            chk("stb", {31'h0, m_stb}, {31'h0, m_cyc});
            chk("sel", {28'h0, m_sel}, m_cyc ? 32'hF : 32'h0);
            if (!running) chk("idle_cyc", {31'h0, m_cyc}, 32'h0);
            if (m_cyc && running) begin
                if (xidx >= nx) begin
                    chk("extra_xfer", xidx, nx);
                end else begin
                    chk("xfer_we", {31'h0, m_we}, {31'h0, xwe[xidx]});
                    chk("xfer_adr", m_adr, xadr[xidx]);
                    if (m_we) chk("xfer_dat", m_dato, xdat[xidx]);
                end
                if (!no_ack) begin
                    if (xidx == err_idx) begin
                        m_err = 1'b1;
                    end else begin
                        m_ack = 1'b1;
                        if (m_we) mem[m_adr] = m_dato;
                        else if (corrupt_en && m_adr == corrupt_adr) m_dati = CORRUPT;
                        else m_dati = mem.exists(m_adr) ? mem[m_adr] : 32'h0;
                    end
                    xidx++;
                    acked_last = 1'b1;
                end
            end
            if (m_cyc) begin
                cyc_len++;
            end else begin
                if (cyc_len != 0) last_cyc_len = cyc_len;
                cyc_len = 0;
            end
            if (running) begin
                offs++;
                if (done) begin
                    chk("done_lat", offs, e_done_at);
                    chk("pass", {31'h0, pass}, (e_code == 2'd0) ? 32'h1 : 32'h0);
                    chk("code", {30'h0, code}, {30'h0, e_code});
                    chk("fail_adr", fadr, e_fadr);
                    chk("fail_dat", fdat, e_fdat);
                    chk("n_xfer", xidx, nx);
                    running = 1'b0;
                    done_cnt++;
                end
            end else begin
                chk("idle_done", {31'h0, done}, 32'h0);
                if (start) begin
                    build();
                    running = 1'b1;
                    offs    = 0;
                    xidx    = 0;
                end
            end
        end
    end

    task automatic go(input logic [31:0] b, input logic [15:0] w, input logic [31:0] s);
        @(posedge clk); #2;
        base  = b;
        words = w;
        seed  = s;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
        #2;
        chk(nm, done_cnt, d0 + 1);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk(nm, {busy, done, pass, code, m_cyc, m_stb, m_we, m_sel} | m_adr | m_dato | fadr | fdat, 32'h0);
    endtask

    initial begin
        int d0;
        bit found;
        #12;
        chk_reset_outs("reset_outs");
        chk("model_step1", model_next(32'h1), 32'h80200003);
        chk("model_step2", model_next(32'h80200003), 32'hC0300002);
        @(posedge clk); #2;
        rst_n = 1'b1;

        d0 = done_cnt;
        go(32'h0, 16'd3, 32'h1);
        wait_done(d0, "t1_done");
        chk("t1_mem0", mem[32'h0], 32'h00000001);
        chk("t1_mem4", mem[32'h4], 32'h80200003);
        chk("t1_mem8", mem[32'h8], 32'hC0300002);
        chk("t1_pass", {31'h0, pass}, 32'h1);

        d0 = done_cnt;
        go(32'h80, 16'd0, 32'h5);
        wait_done(d0, "t2_done");
        chk("t2_pass", {31'h0, pass}, 32'h1);

        corrupt_en  = 1'b1;
        corrupt_adr = 32'h104;
        d0 = done_cnt;
        go(32'h100, 16'd3, 32'h1);
        wait_done(d0, "t3_done");
        chk("t3_code", {30'h0, code}, 32'h1);
        chk("t3_fadr", fadr, 32'h104);
        chk("t3_fdat", fdat, 32'h12345678);
        chk("t3_pass", {31'h0, pass}, 32'h0);
        corrupt_en = 1'b0;

        err_idx = 1;
        d0 = done_cnt;
        go(32'h0, 16'd3, 32'hACE1);
        wait_done(d0, "t4_done");
        chk("t4_code", {30'h0, code}, 32'h2);
        chk("t4_fadr", fadr, 32'h4);
        err_idx = -1;

        no_ack = 1'b1;
        d0 = done_cnt;
        go(32'h200, 16'd2, 32'h7);
`ifdef WB_MEM_BIST_TIMEOUT_EN
        wait_done(d0, "t5_done");
        chk("t5_code", {30'h0, code}, 32'h3);
        chk("t5_fadr", fadr, 32'h200);
        chk("t5_cyc_len", last_cyc_len, TO);
        no_ack = 1'b0;
`else
        repeat (40) @(posedge clk);
        #2;
        chk("t5_hang_cyc", {31'h0, m_cyc}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t5_reset_outs");
        no_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
`endif

        go(32'h40, 16'd4, 32'hACE1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #2;
            if (m_cyc && !m_we) found = 1'b1;
        end
        chk("t6_read_seen", {31'h0, found}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_reset_outs");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        d0 = done_cnt;
        go(32'h13, 16'd2, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        base  = 32'h400;
        words = 16'd7;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(d0, "t7_done");
        chk("t7_pass", {31'h0, pass}, 32'h1);
        chk("t7_mem10", mem[32'h10], 32'h00000001);
        chk("t7_mem14", mem[32'h14], 32'h80200003);
        chk("t7_no400", {31'h0, mem.exists(32'h400) ? 1'b1 : 1'b0}, 32'h0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
